cpu_mem_bridge: RTL and testbench

Bridges the PicoRV32 native memory bus (valid/ready, addr, wdata, wstrb, rdata) onto port B of the dual-port shared RAM. The APB host owns port A of the same RAM.

---
 rtl/flunkyfive_pkg.sv | 20 ++
 rtl/bridge_io_regs.sv | 104 ++++++++++
 rtl/cpu_mem_bridge.sv | 121 ++++++++++++
 tb/tb_cpu_mem_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/flunkyfive_pkg.sv
// Shared definitions for the CPU-side memory bridge.
//   - state_t        : bridge FSM encoding (IDLE / RAM_RD / ACK)
//   - OFF_*          : byte offsets of the IO registers inside the 16-byte block
//   - UNMAPPED_RDATA : value returned for reads of unmapped addresses
package flunkyfive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAM_RD = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [3:0] OFF_DOORBELL = 4'h0;
  localparam logic [3:0] OFF_SCRATCH  = 4'h4;
  localparam logic [3:0] OFF_ERR_ADDR = 4'h8;
  localparam logic [3:0] OFF_TIMER    = 4'hC;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bridge_io_regs.sv
// IO register block of the CPU memory bridge.
// Holds DOORBELL/host_irq, SCRATCH, ERR_ADDR/err_flag and the optional
// free-running timer (present only when CPU_MEM_BRIDGE_TIMER_EN is defined).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   sel             : one-cycle access strobe for this block
//   offset          : byte offset inside the block (bits [1:0] always zero)
//   wstrb, wdata    : write strobes (0 = read) and write data
//   err_set         : unmapped access seen this cycle, capture err_addr_in
//   err_addr_in     : faulting CPU byte address
//   host_irq_clr    : host clears the doorbell interrupt
//   rdata           : combinational read data for the selected offset
//   host_irq        : doorbell interrupt level
//   err_flag        : sticky unmapped-access flag
module bridge_io_regs
  import flunkyfive_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  offset,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        err_set,
  input  logic [31:0] err_addr_in,
  input  logic        host_irq_clr,
  output logic [31:0] rdata,
  output logic        host_irq,
  output logic        err_flag
);

  logic        wr;
  logic [31:0] scratch;
  logic [31:0] err_addr;

  assign wr = sel && (wstrb != 4'h0);

  // Doorbell: a write in the same cycle as a host clear keeps the interrupt
  // asserted, so a ring from the CPU is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_irq <= 1'b0;
    end else if (wr && offset == OFF_DOORBELL) begin
      host_irq <= 1'b1;
    end else if (host_irq_clr) begin
      host_irq <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr && offset == OFF_SCRATCH) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) scratch[8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // An unmapped access and an ERR_ADDR write never share a cycle, since the
  // bridge issues one access per transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr <= '0;
      err_flag <= 1'b0;
    end else if (err_set) begin
      err_addr <= err_addr_in;
      err_flag <= 1'b1;
    end else if (wr && offset == OFF_ERR_ADDR) begin
      err_flag <= 1'b0;
    end
  end

`ifdef CPU_MEM_BRIDGE_TIMER_EN
  logic [31:0] timer;

  // Full-word load regardless of strobes; otherwise free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (wr && offset == OFF_TIMER) begin
      timer <= wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_DOORBELL: rdata = {31'b0, host_irq};
      OFF_SCRATCH:  rdata = scratch;
      OFF_ERR_ADDR: rdata = err_addr;
`ifdef CPU_MEM_BRIDGE_TIMER_EN
      OFF_TIMER:    rdata = timer;
`else
      OFF_TIMER:    rdata = '0;
`endif
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges the PicoRV32 native memory bus onto port B of the shared RAM and a
// small IO register block. Addresses decode into the RAM window
// (0 .. (4<<ADDR_WIDTH)-1), the 16-byte IO block at IO_BASE, and an error
// region covering everything else.
// Optional feature macro: CPU_MEM_BRIDGE_TIMER_EN (adds the timer at IO 0xC).
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb      : CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata            : registered completion pulse and read data
//   ram_we, ram_addr, ram_wdata     : shared-RAM port B controls
//   ram_q                           : port B read data (one-cycle latency)
//   host_irq, host_irq_clr          : doorbell interrupt to host and its clear
//   err_flag                        : sticky unmapped-access flag
module cpu_mem_bridge
  import flunkyfive_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] IO_BASE    = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_q,
  output logic                  host_irq,
  input  logic                  host_irq_clr,
  output logic                  err_flag
);

  // Window size computed in 64 bits so a large ADDR_WIDTH cannot wrap it.
  localparam logic [63:0] RAM_BYTES = 64'd4 << ADDR_WIDTH;

  state_t      state, state_next;
  logic        ram_hit, io_hit;
  logic [31:0] io_off;
  logic        io_sel, err_set, ready_next;
  logic [31:0] io_rdata, rdata_next;

  assign ram_hit   = ({32'd0, mem_addr} < RAM_BYTES);
  // Unsigned subtraction: addresses below IO_BASE wrap to large values.
  assign io_off    = mem_addr - IO_BASE;
  assign io_hit    = !ram_hit && (io_off < 32'd16);
  assign ram_addr  = mem_addr[ADDR_WIDTH+1:2];
  assign ram_wdata = mem_wdata;

  always_comb begin
    state_next = state;
    ram_we     = 4'h0;
    io_sel     = 1'b0;
    err_set    = 1'b0;
    ready_next = 1'b0;
    rdata_next = mem_rdata;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (ram_hit) begin
            if (mem_wstrb != 4'h0) begin
              ram_we     = mem_wstrb;
              ready_next = 1'b1;
              state_next = ST_ACK;
            end else begin
              state_next = ST_RAM_RD;
            end
          end else begin
            io_sel     = io_hit;
            err_set    = !io_hit;
            ready_next = 1'b1;
            state_next = ST_ACK;
            if (mem_wstrb == 4'h0) begin
              rdata_next = io_hit ? io_rdata : UNMAPPED_RDATA;
            end
          end
        end
      end
      ST_RAM_RD: begin
        rdata_next = ram_q;
        ready_next = 1'b1;
        state_next = ST_ACK;
      end
      // The CPU still holds mem_valid here; ignoring it avoids a re-issue.
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stage boundary: FSM state, registered ready pulse and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state     <= state_next;
      mem_ready <= ready_next;
      mem_rdata <= rdata_next;
    end
  end

  bridge_io_regs u_io_regs (
    .clk         (clk),
    .reset       (reset),
    .sel         (io_sel),
    .offset      ({io_off[3:2], 2'b00}),
    .wstrb       (mem_wstrb),
    .wdata       (mem_wdata),
    .err_set     (err_set),
    .err_addr_in (mem_addr),
    .host_irq_clr(host_irq_clr),
    .rdata       (io_rdata),
    .host_irq    (host_irq),
    .err_flag    (err_flag)
  );

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed self-checking bench for cpu_mem_bridge with a behavioural
// one-cycle-latency RAM on port B.
module tb_cpu_mem_bridge;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_q;
  logic          host_irq, host_irq_clr, err_flag;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] ram_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_q <= ram_mem[ram_addr];
  end

  cpu_mem_bridge #(.ADDR_WIDTH(AW), .IO_BASE(32'h1000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_q       (ram_q),
    .host_irq    (host_irq),
    .host_irq_clr(host_irq_clr),
    .err_flag    (err_flag)
  );

  // Bus driver: request issued #1 after a rising edge (cycle N); returns
  // ram_we/ram_addr seen in cycle N, cycles until mem_ready, and mem_rdata.
  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic clr, output logic [3:0] we0, output logic [AW-1:0] ad0,
                          output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; host_irq_clr = clr;
    #1;
    we0 = ram_we; ad0 = ram_addr; lat = 0;
    do begin
      @(posedge clk); #1;
      host_irq_clr = 1'b0;
      lat++;
    end while (!mem_ready && lat < 8);
    if (!mem_ready) begin
      n_total++;
      $display("FAIL timeout: no mem_ready for addr %h within %0d cycles", a, lat);
    end
    rd = mem_rdata;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    host_irq_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    n_total++; if (mem_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", mem_ready); else n_pass++;
    n_total++; if (mem_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", mem_rdata); else n_pass++;
    n_total++; if (host_irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", host_irq); else n_pass++;
    n_total++; if (err_flag !== 1'b0) $display("FAIL rst_err: got %b want 0", err_flag); else n_pass++;
    n_total++; if (ram_we !== 4'h0) $display("FAIL rst_we: got %h want 0", ram_we); else n_pass++;
  endtask

  task automatic test_ram_rw();
    logic [3:0] we0; logic [AW-1:0] ad0; int lat; logic [31:0] rd;
    bus_xfer(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, we0, ad0, lat, rd);
    n_total++; if (we0 !== 4'hF) $display("FAIL ram_wr_we: got %h want f", we0); else n_pass++;
    n_total++; if (ad0 !== 14'd4) $display("FAIL ram_wr_addr: got %0d want 4", ad0); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL ram_wr_lat: got %0d want 1", lat); else n_pass++;
    bus_xfer(32'h0000_0010, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (we0 !== 4'h0) $display("FAIL ram_rd_we: got %h want 0", we0); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL ram_rd_lat: got %0d want 2", lat); else n_pass++;
    n_total++; if (rd !== 32'h1234_5678) $display("FAIL ram_rd_data: got %h want 12345678", rd); else n_pass++;
    repeat (2) @(posedge clk); #1;
    n_total++; if (mem_rdata !== 32'h1234_5678) $display("FAIL ram_rd_hold: got %h want 12345678", mem_rdata); else n_pass++;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL ready_pulse: got %b want 0", mem_ready); else n_pass++;
    // Last word of the window is RAM; the next byte is unmapped.
    bus_xfer(32'h0000_FFFC, 32'hCAFE_F00D, 4'hF, 1'b0, we0, ad0, lat, rd);
    n_total++; if (ad0 !== 14'h3FFF || we0 !== 4'hF) $display("FAIL ram_top_wr: got we %h addr %h want f 3fff", we0, ad0); else n_pass++;
    bus_xfer(32'h0000_FFFC, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'hCAFE_F00D) $display("FAIL ram_top_rd: got %h want cafef00d", rd); else n_pass++;
    n_total++; if (err_flag !== 1'b0) $display("FAIL ram_top_err: got %b want 0", err_flag); else n_pass++;
  endtask

  task automatic test_byte_strobe();
    logic [3:0] we0; logic [AW-1:0] ad0; int lat; logic [31:0] rd;
    bus_xfer(32'h1000_0004, 32'h0, 4'hF, 1'b0, we0, ad0, lat, rd);
    bus_xfer(32'h1000_0004, 32'hAABB_CCDD, 4'b0100, 1'b0, we0, ad0, lat, rd);
    n_total++; if (we0 !== 4'h0) $display("FAIL io_wr_we: got %h want 0", we0); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL io_wr_lat: got %0d want 1", lat); else n_pass++;
    bus_xfer(32'h1000_0004, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h00BB_0000) $display("FAIL scratch_byte: got %h want 00bb0000", rd); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL io_rd_lat: got %0d want 1", lat); else n_pass++;
  endtask

  task automatic test_doorbell();
    logic [3:0] we0; logic [AW-1:0] ad0; int lat; logic [31:0] rd;
    bus_xfer(32'h1000_0000, 32'h1, 4'h1, 1'b1, we0, ad0, lat, rd);
    n_total++; if (host_irq !== 1'b1) $display("FAIL irq_race: got %b want 1", host_irq); else n_pass++;
    bus_xfer(32'h1000_0000, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h1) $display("FAIL db_read1: got %h want 1", rd); else n_pass++;
    @(posedge clk); #1; host_irq_clr = 1'b1;
    @(posedge clk); #1; host_irq_clr = 1'b0;
    n_total++; if (host_irq !== 1'b0) $display("FAIL irq_clr: got %b want 0", host_irq); else n_pass++;
    bus_xfer(32'h1000_0000, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL db_read0: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [3:0] we0; logic [AW-1:0] ad0; int lat; logic [31:0] rd;
    bus_xfer(32'h2000_0004, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL unm_rd: got %h want deadbeef", rd); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL unm_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (err_flag !== 1'b1) $display("FAIL unm_flag: got %b want 1", err_flag); else n_pass++;
    bus_xfer(32'h1000_0008, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h2000_0004) $display("FAIL err_addr: got %h want 20000004", rd); else n_pass++;
    bus_xfer(32'h1000_0008, 32'h0, 4'hF, 1'b0, we0, ad0, lat, rd);
    n_total++; if (err_flag !== 1'b0) $display("FAIL err_clr: got %b want 0", err_flag); else n_pass++;
    n_total++; if (mem_rdata !== 32'h2000_0004) $display("FAIL wr_keeps_rdata: got %h want 20000004", mem_rdata); else n_pass++;
    bus_xfer(32'h1000_0008, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h2000_0004) $display("FAIL err_addr_kept: got %h want 20000004", rd); else n_pass++;
    // First byte past the RAM window is unmapped, and writes there are dropped.
    bus_xfer(32'h0001_0000, 32'h5555_5555, 4'hF, 1'b0, we0, ad0, lat, rd);
    n_total++; if (we0 !== 4'h0 || err_flag !== 1'b1) $display("FAIL unm_wr: got we %h flag %b want 0 1", we0, err_flag); else n_pass++;
    bus_xfer(32'h1000_0008, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h0001_0000) $display("FAIL err_addr_top: got %h want 00010000", rd); else n_pass++;
    bus_xfer(32'h1000_0008, 32'h0, 4'hF, 1'b0, we0, ad0, lat, rd);
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] we0; logic [AW-1:0] ad0; int lat; logic [31:0] rd;
    bus_xfer(32'h1000_0000, 32'h1, 4'hF, 1'b0, we0, ad0, lat, rd);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h0000_0010; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_valid = 1'b0;
    n_total++; if (mem_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", mem_ready); else n_pass++;
    n_total++; if (mem_rdata !== 32'h0) $display("FAIL midrst_rdata: got %h want 0", mem_rdata); else n_pass++;
    n_total++; if (host_irq !== 1'b0) $display("FAIL midrst_irq: got %b want 0", host_irq); else n_pass++;
    bus_xfer(32'h0000_0010, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (lat !== 2 || rd !== 32'h1234_5678) $display("FAIL midrst_fresh: got lat %0d data %h want 2 12345678", lat, rd); else n_pass++;
    bus_xfer(32'h1000_0004, 32'h0, 4'h0, 1'b0, we0, ad0, lat, rd);
    n_total++; if (rd !== 32'h0) $display("FAIL midrst_scratch: got %h want 0", rd); else n_pass++;
  endtask

  task automatic test_timer();
    logic [3:0] we0; logic [AW-1:0] ad0; int lat; logic [31:0] t1, t2;
`ifdef CPU_MEM_BRIDGE_TIMER_EN
    bus_xfer(32'h1000_000C, 32'hFFFF_FFFE, 4'h1, 1'b0, we0, ad0, lat, t1);
    bus_xfer(32'h1000_000C, 32'h0, 4'h0, 1'b0, we0, ad0, lat, t1);
    repeat (2) @(posedge clk);
    bus_xfer(32'h1000_000C, 32'h0, 4'h0, 1'b0, we0, ad0, lat, t2);
    n_total++; if (t1 !== 32'hFFFF_FFFF) $display("FAIL timer_t1: got %h want ffffffff", t1); else n_pass++;
    n_total++; if (t2 - t1 !== 32'd4) $display("FAIL timer_delta: got %h want 4", t2 - t1); else n_pass++;
    n_total++; if (t2 !== 32'h3) $display("FAIL timer_wrap: got %h want 3", t2); else n_pass++;
`else
    bus_xfer(32'h1000_000C, 32'h0, 4'h0, 1'b0, we0, ad0, lat, t1);
    n_total++; if (t1 !== 32'h0) $display("FAIL timer_off_rd: got %h want 0", t1); else n_pass++;
    n_total++; if (err_flag !== 1'b0) $display("FAIL timer_off_err: got %b want 0", err_flag); else n_pass++;
    bus_xfer(32'h1000_000C, 32'h1234_0000, 4'hF, 1'b0, we0, ad0, lat, t2);
    bus_xfer(32'h1000_000C, 32'h0, 4'h0, 1'b0, we0, ad0, lat, t2);
    n_total++; if (t2 !== 32'h0) $display("FAIL timer_off_wr: got %h want 0", t2); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_byte_strobe();
    test_doorbell();
    test_unmapped();
    test_reset_mid_read();
    test_timer();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
